player_input: RTL
=================

# player_input

Per-player command generator that drives the move/jump command inputs of the player movement block. Conditions three raw push-buttons with a synchronizer and debounce, then resolves simultaneous left+right as last-pressed-wins. It turns jump presses into a one-frame request pulse, using the mover's jump_active flag as a busy/acknowledge. All command outputs change only on frame ticks (SCEN), so the mover samples stable values.

## Interface
- DB_CYCLES, 500000: clocks a synchronized button must differ from its debounced value before the debounced value flips (5 ms at 100 MHz).
- DB_WIDTH, 20: width of each debounce counter; must satisfy 2^DB_WIDTH > DB_CYCLES.
- BUFFER_FRAMES, 6: SCEN ticks a pending jump stays alive (used only with JUMP_BUFFER_EN).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- SCEN  in  1  one-clock frame-tick strobe, shared with the mover.
- enable  in  1  commands permitted (same signal as mover move_enable).
- btn_left, btn_right, btn_jump  in  1 each  raw asynchronous buttons, active-high.
- jump_active  in  1  mover airborne flag (busy).
- move_left  out  1  walk-left command, registered.
- move_right  out  1  walk-right command, registered; never high together with move_left.
- jump  out  1  jump request, registered, high for exactly one SCEN period per accepted press.
- btn_state  out  3  debounced {jump, right, left}, for LEDs/debug.

## Operation
- Synchronizer: 2 flops per button; reset value 0.
- Debounce, per button: counter cleared when sync == debounced. Otherwise it increments. When counter == DB_CYCLES-1 while the mismatch persists, debounced <= sync and counter clears.
- Direction resolution: last_dir register (NONE/LEFT/RIGHT):
  - A debounced rising edge of left sets LEFT; a rising edge of right sets RIGHT. If both rise in the same clock, last_dir holds its value.
  - Resolved direction: both held → last_dir; only one held → that one; none held → NONE.
- Jump request: a debounced rising edge of jump sets jump_req. Holding the button never re-arms; a release then a new press is required.
- Output update, only on clocks with SCEN=1:
  - enable=0: move_left, move_right, jump <= 0; jump_req cleared.
  - enable=1: move_left/move_right <= resolved direction.
  - jump <= 1 iff jump_req && !jump_active && !jump; on fire, jump_req clears. Otherwise jump <= 0.
  - No JUMP_BUFFER_EN: an unfired jump_req clears at that SCEN. Pressing while airborne is therefore discarded.
- A press arriving on the same clock as SCEN is seen at the next SCEN.
- Between SCEN ticks, outputs hold.
- Reset: all outputs 0, btn_state 0, counters 0, last_dir NONE, jump_req 0, buffer age 0. Reset mid-debounce or mid-pulse aborts immediately.

## Timing
- Raw edge to btn_state: 2 + DB_CYCLES clocks.
- Edge detect to output: registered at the first SCEN clock after the debounced edge. The mover samples it at the following SCEN.
- jump high from SCEN edge k to SCEN edge k+1 exactly. The mover raises jump_active at edge k+1, so the next request can fire no earlier than the SCEN after jump_active falls.
- move_left/move_right are mutually exclusive on every clock.

## Configuration
- JUMP_BUFFER_EN defined: pending jump_req survives up to BUFFER_FRAMES SCEN ticks while blocked.
  - Blocked means jump_active=1, or the jump output is already high.
  - An age counter of width $clog2(BUFFER_FRAMES+1) increments per blocked SCEN. The request is dropped at the SCEN where age reaches BUFFER_FRAMES.
  - It fires at the first unblocked SCEN within that window.
  - A new press while one is pending restarts age at 0.
- JUMP_BUFFER_EN undefined: no age counter; a blocked request is dropped at its first SCEN.

## Structure
- Shared package fighter_pkg holds:
  - the direction enum (DIR_NONE, DIR_LEFT, DIR_RIGHT);
  - default DB_CYCLES and BUFFER_FRAMES constants, shared with the mover's SPEED/JUMP_FRAMES family.
- Sub-module btn_debounce (synchronizer + counter + debounced output + rising-edge pulse), instantiated three times.
- The top-level holds direction resolution, the jump request/buffer, and the SCEN output registers.

## Test plan
Bench settings: DB_CYCLES=4, SCEN every 10 clocks.
- Glitch rejection: btn_left high for 3 clocks, then low → btn_state[0] stays 0 and move_left never asserts.
- Press latency: btn_left held → btn_state[0]=1 at 6 clocks; move_left=1 at the next SCEN edge.
- Last-wins: left held, then right pressed → move_right=1, move_left=0 at the next SCEN. Release right → move_left=1 at the following SCEN.
- Jump pulse: jump pressed and held, jump_active=0 → jump high for exactly 10 clocks (one SCEN period), no second pulse while held. A release and re-press produces a new pulse.
- Blocked jump: press while jump_active=1, then jump_active falls after 3 SCENs.
  - Without JUMP_BUFFER_EN: no pulse.
  - With it (BUFFER_FRAMES=6): pulse at that SCEN.
  - With it, jump_active falls after 8 SCENs: no pulse.
- Enable and reset:
  - enable=0 with all buttons held → outputs 0 at the next SCEN.
  - reset asserted mid-pulse → all outputs 0 asynchronously; no pulse resumes after release until a fresh press.

Source files
------------

// File: rtl/fighter_pkg.sv
// Shared definitions for the fighter player blocks: direction encoding,
// default timing constants and the held-button direction resolver.
package fighter_pkg;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    // 5 ms of debounce at 100 MHz; the counter width must cover DB_CYCLES-1
    localparam int DEFAULT_DB_CYCLES     = 500000;
    localparam int DEFAULT_DB_WIDTH      = 20;

    // Frames a blocked jump press is remembered when jump buffering is built in
    localparam int DEFAULT_BUFFER_FRAMES = 6;

    // Both held -> most recently pressed wins; one held -> that one; none -> NONE
    function automatic dir_t resolve_dir(input logic left_held,
                                         input logic right_held,
                                         input dir_t last_dir);
        if (left_held && right_held) begin
            return last_dir;
        end else if (left_held) begin
            return DIR_LEFT;
        end else if (right_held) begin
            return DIR_RIGHT;
        end
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: two-flop synchronizer, mismatch counter,
// debounced level and a one-clock strobe on the clock the level rises.
// The strobe is high on the clock before 'level' reads 1, so state that
// reacts to it updates on the same edge as the level itself.
module btn_debounce
    import fighter_pkg::*;
#(
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
    parameter int DB_WIDTH  = DEFAULT_DB_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [DB_WIDTH-1:0] LAST_COUNT = DB_WIDTH'(DB_CYCLES - 1);

    logic [1:0]          sync;
    logic [DB_WIDTH-1:0] count;

    assign rise = sync[1] && !level && (count == LAST_COUNT);

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], raw};
        end
    end

    // Flip the debounced level only after DB_CYCLES consecutive mismatches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            level <= 1'b0;
        end else if (sync[1] == level) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            level <= sync[1];
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/player_input.sv
// Per-player command generator for the movement block. Debounces the three
// buttons, resolves left/right as last-pressed-wins, turns jump presses into
// one-frame requests and only updates commands on SCEN frame ticks.
// Optional feature macro: JUMP_BUFFER_EN keeps a blocked jump press alive
// for up to BUFFER_FRAMES frames instead of dropping it at the first frame.
module player_input
    import fighter_pkg::*;
#(
    parameter int DB_CYCLES     = DEFAULT_DB_CYCLES,
    parameter int DB_WIDTH      = DEFAULT_DB_WIDTH,
    parameter int BUFFER_FRAMES = DEFAULT_BUFFER_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCEN,
    input  logic       enable,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       jump_active,
    output logic       move_left,
    output logic       move_right,
    output logic       jump,
    output logic [2:0] btn_state
);

    logic [2:0] raw_btn;
    logic [2:0] level;
    logic [2:0] rise;

    dir_t last_dir;
    dir_t held_dir;

    logic jump_req;
    logic jump_req_next;
    logic move_left_next;
    logic move_right_next;
    logic jump_next;

`ifdef JUMP_BUFFER_EN
    localparam int AGE_W = $clog2(BUFFER_FRAMES + 1);
    localparam logic [AGE_W-1:0] LAST_AGE = AGE_W'(BUFFER_FRAMES - 1);

    logic [AGE_W-1:0] age;
    logic [AGE_W-1:0] age_next;
`else
    // Buffer depth has no role when the buffer is compiled out
    logic unused_buffer_cfg;
    assign unused_buffer_cfg = ^BUFFER_FRAMES;
`endif

    assign raw_btn   = {btn_jump, btn_right, btn_left};
    assign btn_state = level;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES),
            .DB_WIDTH (DB_WIDTH)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_btn[i]),
            .level(level[i]),
            .rise (rise[i])
        );
    end

    // Remember which direction was pressed most recently; a tie keeps the old one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_dir <= DIR_NONE;
        end else if (rise[0] && !rise[1]) begin
            last_dir <= DIR_LEFT;
        end else if (rise[1] && !rise[0]) begin
            last_dir <= DIR_RIGHT;
        end
    end

    // Direction implied by the buttons currently held
    always_comb begin
        held_dir = resolve_dir(level[0], level[1], last_dir);
    end

    // Frame-tick command update and jump request bookkeeping
    always_comb begin
        move_left_next  = move_left;
        move_right_next = move_right;
        jump_next       = jump;
        jump_req_next   = jump_req;
`ifdef JUMP_BUFFER_EN
        age_next        = age;
`endif
        if (SCEN) begin
            if (!enable) begin
                move_left_next  = 1'b0;
                move_right_next = 1'b0;
                jump_next       = 1'b0;
                jump_req_next   = 1'b0;
`ifdef JUMP_BUFFER_EN
                age_next        = '0;
`endif
            end else begin
                move_left_next  = (held_dir == DIR_LEFT);
                move_right_next = (held_dir == DIR_RIGHT);
                jump_next       = 1'b0;
                if (jump_req && !jump_active && !jump) begin
                    jump_next     = 1'b1;
                    jump_req_next = 1'b0;
`ifdef JUMP_BUFFER_EN
                    age_next      = '0;
`endif
                end else begin
`ifdef JUMP_BUFFER_EN
                    if (jump_req) begin
                        if (age == LAST_AGE) begin
                            jump_req_next = 1'b0;
                            age_next      = '0;
                        end else begin
                            age_next = age + 1'b1;
                        end
                    end
`else
                    jump_req_next = 1'b0;
`endif
                end
            end
        end
        if (rise[2]) begin
            jump_req_next = 1'b1;
`ifdef JUMP_BUFFER_EN
            age_next      = '0;
`endif
        end
    end

    // Command and request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            move_left  <= 1'b0;
            move_right <= 1'b0;
            jump       <= 1'b0;
            jump_req   <= 1'b0;
        end else begin
            move_left  <= move_left_next;
            move_right <= move_right_next;
            jump       <= jump_next;
            jump_req   <= jump_req_next;
        end
    end

`ifdef JUMP_BUFFER_EN
    // Age of the pending jump request, in blocked frames
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age <= '0;
        end else begin
            age <= age_next;
        end
    end
`endif

endmodule
